// File: rtl/pool_accum_unit_pkg.sv
// Shared types for the pooling accumulator: FSM states, pooling modes and
// the accumulator width rule used by the top level and every lane.
package pool_accum_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  // One extra bit beyond the window index keeps a full-window sum from overflowing.
  function automatic int acc_width(input int data_width, input int index_width);
    return data_width + index_width + 1;
  endfunction

endpackage

// File: rtl/pool_accum_unit_if.sv
// Handshake bundle for the pooling unit: configuration/start, input element
// stream and output result stream.
interface pool_accum_unit_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int SHIFT_WIDTH = 5
);

  logic                                 i_start;
  logic                                 i_mode;
  logic [INDEX_WIDTH:0]                 i_win_len;
  logic signed [DATA_WIDTH-1:0]         i_scale;
  logic [SHIFT_WIDTH-1:0]               i_shift;
  logic                                 i_valid;
  logic                                 o_ready;
  logic [DATA_COPIES*DATA_WIDTH-1:0]    i_mdata;
  logic                                 o_valid;
  logic                                 i_ready;
  logic [DATA_COPIES*2*DATA_WIDTH-1:0]  o_result;
  logic                                 o_busy;

  modport slave (
    input  i_start, i_mode, i_win_len, i_scale, i_shift,
    input  i_valid, i_mdata, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );

  modport master (
    output i_start, i_mode, i_win_len, i_scale, i_shift,
    output i_valid, i_mdata, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

endinterface

// File: rtl/pool_accum_unit_lane.sv
// One pooling lane: running sum or running max, then scale, round and
// saturate the sum into a 2*DATA_WIDTH result register.
module pool_lane
  import pool_accum_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 5,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_load,
  input  logic                          i_accum,
  input  logic                          i_capture,
  input  mode_e                         i_mode,
  input  logic signed [DATA_WIDTH-1:0]  i_scale,
  input  logic [SHIFT_WIDTH-1:0]        i_shift,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  output logic [2*DATA_WIDTH-1:0]       o_result
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, INDEX_WIDTH);
  localparam int RES_WIDTH = 2 * DATA_WIDTH;
  // Wide enough for the product plus a rounding constant at the largest shift.
  localparam int EXT_WIDTH = ACC_WIDTH + DATA_WIDTH + (1 << SHIFT_WIDTH);

  localparam logic signed [EXT_WIDTH-1:0] ONE     = EXT_WIDTH'(1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX =
    {{(EXT_WIDTH-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN =
    {{(EXT_WIDTH-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, elem_ext;
  logic [RES_WIDTH-1:0]        result_q, result_d;
  logic signed [EXT_WIDTH-1:0] acc_ext, scale_ext, prod, rnd, rounded, shifted;

  always_comb begin
    elem_ext = {{(ACC_WIDTH-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
    acc_d    = acc_q;
    if (i_load) begin
      acc_d = elem_ext;
    end else if (i_accum) begin
      if (i_mode == MODE_MAX) begin
        if (elem_ext > acc_q) acc_d = elem_ext;
      end else begin
        acc_d = acc_q + elem_ext;
      end
    end
  end

  always_comb begin
    acc_ext   = {{(EXT_WIDTH-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
    scale_ext = {{(EXT_WIDTH-DATA_WIDTH){i_scale[DATA_WIDTH-1]}}, i_scale};
    prod      = acc_ext * scale_ext;
    rnd       = '0;
    if (i_shift != '0) rnd = ONE << (i_shift - SHIFT_WIDTH'(1));
    rounded   = prod + rnd;
    shifted   = rounded >>> i_shift;
    result_d  = result_q;
    if (i_capture) begin
      if (i_mode == MODE_MAX) begin
        result_d = {{DATA_WIDTH{acc_q[DATA_WIDTH-1]}}, acc_q[DATA_WIDTH-1:0]};
      end else if (shifted > SAT_MAX) begin
        result_d = SAT_MAX[RES_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
        result_d = SAT_MIN[RES_WIDTH-1:0];
      end else begin
        result_d = shifted[RES_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;

endmodule

// File: rtl/pool_accum_unit.sv
// Pooling accumulator top: window FSM, element counter and configuration
// registers driving DATA_COPIES parallel pool_lane instances.
module pool_accum_unit
  import pool_accum_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pool_accum_unit_if.slave  bus
);

  localparam int LEN_WIDTH = INDEX_WIDTH + 1;
  localparam int RES_WIDTH = 2 * DATA_WIDTH;

  state_e                       state_q, state_d;
  mode_e                        mode_q, mode_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d, cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] scale_q, scale_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
  logic                         ready_q, ready_d, busy_q, busy_d, valid_q, valid_d;
  logic                         accept, first_elem, last_elem;
  logic [DATA_COPIES*RES_WIDTH-1:0] result_all;

  assign accept     = bus.i_valid && ready_q;
  assign first_elem = (cnt_q == '0);
  assign last_elem  = ((cnt_q + LEN_WIDTH'(1)) == len_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    scale_d = scale_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_ACCUM;
          mode_d  = mode_e'(bus.i_mode);
          len_d   = (bus.i_win_len == '0) ? LEN_WIDTH'(1) : bus.i_win_len;
          scale_d = bus.i_scale;
          shift_d = bus.i_shift;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (last_elem) state_d = ST_SCALE;
        end
      end
      ST_SCALE: state_d = ST_OUT;
      ST_OUT: begin
        if (valid_q && bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Valid waits one cycle in OUT so the freshly captured result settles first.
    ready_d = (state_d == ST_ACCUM);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_q == ST_OUT) && (state_d == ST_OUT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_AVG;
      len_q   <= '0;
      cnt_q   <= '0;
      scale_q <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      scale_q <= scale_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
    pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_WIDTH(INDEX_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (accept && first_elem),
      .i_accum  (accept && !first_elem),
      .i_capture(state_q == ST_SCALE),
      .i_mode   (mode_q),
      .i_scale  (scale_q),
      .i_shift  (shift_q),
      .i_data   (bus.i_mdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_result (result_all[g*RES_WIDTH +: RES_WIDTH])
    );
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_all;

endmodule

// File: tb/tb_pool_accum_unit.sv
// Scoreboard bench for pool_accum_unit: a behavioural lane model predicts each
// window's result, which is queued at start and popped when o_valid appears.
module tb_pool_accum_unit;

  localparam int DW   = 8;
  localparam int DC   = 32;
  localparam int IW   = 5;
  localparam int SW   = 5;
  localparam int RW   = 2 * DW;
  localparam int MAXW = 1 << IW;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;

  always #5 i_clk = ~i_clk;

  pool_accum_unit_if #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .INDEX_WIDTH(IW), .SHIFT_WIDTH(SW)) bus ();

  pool_accum_unit #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .INDEX_WIDTH(IW), .SHIFT_WIDTH(SW)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int elems [DC][MAXW];
  logic [DC*RW-1:0] exp_q [$];
  logic [DC*RW-1:0] last_exp;
  logic [DC*RW-1:0] last_result;
  int last_latency;

  function automatic logic [RW-1:0] model_lane(input int lane, input int n, input bit mode,
                                               input int scale, input int shift);
    longint acc, p, lim_hi, lim_lo;
    acc = elems[lane][0];
    for (int i = 1; i < n; i++) begin
      if (mode) begin
        if (elems[lane][i] > acc) acc = elems[lane][i];
      end else begin
        acc = acc + elems[lane][i];
      end
    end
    if (mode) return RW'(acc);
    p = acc * scale;
    if (shift > 0) p = p + (longint'(1) <<< (shift - 1));
    p = p >>> shift;
    lim_hi = (longint'(1) <<< (RW - 1)) - 1;
    lim_lo = -(longint'(1) <<< (RW - 1));
    if (p > lim_hi) p = lim_hi;
    if (p < lim_lo) p = lim_lo;
    return RW'(p);
  endfunction

  task automatic fill_random();
    for (int l = 0; l < DC; l++)
      for (int e = 0; e < MAXW; e++)
        elems[l][e] = int'($urandom_range(255)) - 128;
  endtask

  task automatic fill_const(input int v);
    for (int l = 0; l < DC; l++)
      for (int e = 0; e < MAXW; e++)
        elems[l][e] = v;
  endtask

  task automatic put_elem(input int e);
    for (int l = 0; l < DC; l++) bus.i_mdata[l*DW +: DW] = DW'(elems[l][e]);
  endtask

  task automatic put_junk();
    for (int l = 0; l < DC; l++) bus.i_mdata[l*DW +: DW] = DW'($urandom_range(255));
  endtask

  task automatic idle_inputs();
    bus.i_start   = 1'b0;
    bus.i_mode    = 1'b0;
    bus.i_win_len = '0;
    bus.i_scale   = '0;
    bus.i_shift   = '0;
    bus.i_valid   = 1'b0;
    bus.i_mdata   = '0;
    bus.i_ready   = 1'b1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!bus.o_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    total++;
    if (bus.o_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_timeout: o_ready=%b required 1", bus.o_ready);
    end
  endtask

  task automatic send_window(input bit mode, input logic [IW:0] win, input int scale,
                             input int shift, input bit gaps);
    int n, edges;
    logic [DC*RW-1:0] expv;
    n = (win == 0) ? 1 : int'(win);
    for (int l = 0; l < DC; l++) expv[l*RW +: RW] = model_lane(l, n, mode, scale, shift);
    exp_q.push_back(expv);
    last_result = 'x;
    @(negedge i_clk);
    bus.i_start   = 1'b1;
    bus.i_mode    = mode;
    bus.i_win_len = win;
    bus.i_scale   = DW'(scale);
    bus.i_shift   = SW'(shift);
    @(negedge i_clk);
    bus.i_start   = 1'b0;
    bus.i_scale   = DW'($urandom_range(255));
    bus.i_shift   = SW'($urandom_range(31));
    bus.i_win_len = (IW+1)'($urandom_range(63));
    bus.i_mode    = ~mode;
    wait_ready();
    for (int e = 0; e < n; e++) begin
      if (gaps && $urandom_range(1) == 1) begin
        bus.i_valid = 1'b0;
        put_junk();
        @(negedge i_clk);
      end
      bus.i_valid = 1'b1;
      put_elem(e);
      @(negedge i_clk);
    end
    bus.i_valid = 1'b0;
    edges = 0;
    while (!bus.o_valid && edges < 10) begin
      @(negedge i_clk);
      edges++;
    end
    last_latency = edges;
    total++;
    if (bus.o_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL valid_timeout: o_valid=%b required 1", bus.o_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      last_exp = exp_q.pop_front();
      total++;
      if (bus.o_result !== last_exp) begin
        bad++;
        $display("[TB] FAIL result: got %h required %h", bus.o_result, last_exp);
      end
      last_result = bus.o_result;
      if (bus.i_ready) begin
        @(negedge i_clk);
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL release: valid=%b busy=%b required 0 0", bus.o_valid, bus.o_busy);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b required 0", bus.o_valid); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b required 0", bus.o_busy); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b required 0", bus.o_ready); end
    total++; if (bus.o_result !== '0) begin bad++; $display("[TB] FAIL reset_result: got %h required 0", bus.o_result); end
    idle_inputs();
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_average();
    fill_random();
    elems[0][0] = 10; elems[0][1] = 20; elems[0][2] = 30; elems[0][3] = 40;
    send_window(1'b0, 6'd4, 64, 8, 1'b0);
    total++;
    if (last_latency !== 2) begin bad++; $display("[TB] FAIL avg_latency: got %0d required 2", last_latency); end
    total++;
    if (last_result[0 +: RW] !== 16'd25) begin bad++; $display("[TB] FAIL avg_lane0: got %0d required 25", $signed(last_result[0 +: RW])); end
  endtask

  task automatic test_max();
    fill_random();
    elems[3][0] = -5; elems[3][1] = 3; elems[3][2] = -1;
    send_window(1'b1, 6'd3, int'($urandom_range(255)) - 128, int'($urandom_range(31)), 1'b1);
    total++;
    if (last_result[3*RW +: RW] !== 16'd3) begin bad++; $display("[TB] FAIL max_lane3: got %h required 0003", last_result[3*RW +: RW]); end
    fill_random();
    elems[0][0] = -128;
    send_window(1'b1, 6'd1, 5, 3, 1'b0);
    total++;
    if (last_result[0 +: RW] !== 16'hFF80) begin bad++; $display("[TB] FAIL max_neg: got %h required ff80", last_result[0 +: RW]); end
  endtask

  task automatic test_saturation();
    fill_const(127);
    send_window(1'b0, 6'd32, 127, 0, 1'b0);
    total++;
    if (last_result !== {DC{16'h7FFF}}) begin bad++; $display("[TB] FAIL sat_pos: got %h required all 7fff", last_result); end
    fill_const(-128);
    send_window(1'b0, 6'd32, 127, 0, 1'b1);
    total++;
    if (last_result !== {DC{16'h8000}}) begin bad++; $display("[TB] FAIL sat_neg: got %h required all 8000", last_result); end
  endtask

  task automatic test_rounding();
    fill_random();
    elems[0][0] = -3;
    send_window(1'b0, 6'd1, 1, 1, 1'b0);
    total++;
    if (last_result[0 +: RW] !== 16'hFFFF) begin bad++; $display("[TB] FAIL round_win1: got %h required ffff", last_result[0 +: RW]); end
    send_window(1'b0, 6'd0, 1, 1, 1'b0);
    total++;
    if (last_result[0 +: RW] !== 16'hFFFF) begin bad++; $display("[TB] FAIL round_win0: got %h required ffff", last_result[0 +: RW]); end
  endtask

  task automatic test_backpressure();
    fill_random();
    bus.i_ready = 1'b0;
    send_window(1'b0, 6'd2, int'($urandom_range(255)) - 128, int'($urandom_range(8)), 1'b0);
    for (int c = 0; c < 3; c++) begin
      bus.i_start   = 1'b1;
      bus.i_mode    = 1'b1;
      bus.i_win_len = 6'd1;
      bus.i_valid   = 1'b1;
      put_junk();
      @(negedge i_clk);
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_hold: valid=%b ready=%b busy=%b required 1 0 1", bus.o_valid, bus.o_ready, bus.o_busy);
      end
      total++;
      if (bus.o_result !== last_exp) begin bad++; $display("[TB] FAIL bp_result: got %h required %h", bus.o_result, last_exp); end
    end
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_release: valid=%b busy=%b required 0 0", bus.o_valid, bus.o_busy);
    end
    fill_random();
    send_window(1'b1, 6'd5, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_window();
    fill_const(100);
    @(negedge i_clk);
    bus.i_start   = 1'b1;
    bus.i_mode    = 1'b0;
    bus.i_win_len = 6'd4;
    bus.i_scale   = 8'sd64;
    bus.i_shift   = 5'd6;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    wait_ready();
    for (int e = 0; e < 2; e++) begin
      bus.i_valid = 1'b1;
      put_elem(e);
      @(negedge i_clk);
    end
    bus.i_valid = 1'b0;
    i_rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midrst_state: valid=%b busy=%b required 0 0", bus.o_valid, bus.o_busy);
      end
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_after: valid=%b required 0", bus.o_valid); end
    fill_const(1);
    send_window(1'b0, 6'd4, 64, 6, 1'b0);
    total++;
    if (last_result[0 +: RW] !== 16'd4) begin bad++; $display("[TB] FAIL midrst_fresh: got %0d required 4", $signed(last_result[0 +: RW])); end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) begin
      fill_random();
      send_window(1'($urandom_range(1)), (IW+1)'($urandom_range(32)),
                  int'($urandom_range(255)) - 128, int'($urandom_range(31)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_max();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_mid_window();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pool_accum_unit.md
POOL_ACCUM_UNIT -- requirements
Module: pool_accum_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed element width per lane.
REQ-002 Parameter DATA_COPIES, default 32: number of parallel lanes.
REQ-003 Parameter INDEX_WIDTH, default 5: window-length field is INDEX_WIDTH+1 bits, so the maximum window is 2^INDEX_WIDTH elements.
REQ-004 Parameter SHIFT_WIDTH, default 5: width of the right-shift field.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
REQ-006 i_clk  input  1  clock; all state updates on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_start  input  1  one-cycle pulse that latches configuration and begins a window; honoured only in IDLE.
REQ-009 i_mode  input  1  0 = average (sum x scale >> shift), 1 = max.
REQ-010 i_win_len  input  INDEX_WIDTH+1  number of elements in the window; value 0 is treated as 1.
REQ-011 i_scale  input  DATA_WIDTH  signed reciprocal multiplier used in average mode.
REQ-012 i_shift  input  SHIFT_WIDTH  arithmetic right-shift amount used in average mode.
REQ-013 i_valid  input  1  i_mdata is valid this cycle.
REQ-014 o_ready  output  1  block accepts i_mdata this cycle.
REQ-015 i_mdata  input  DATA_COPIES*DATA_WIDTH  packed signed lanes; lane i occupies [DATA_WIDTH*i +: DATA_WIDTH].
REQ-016 o_valid  output  1  o_result is valid.
REQ-017 i_ready  input  1  downstream accepts o_result.
REQ-018 o_result  output  DATA_COPIES*2*DATA_WIDTH  packed signed results; lane i occupies [2*DATA_WIDTH*i +: 2*DATA_WIDTH].
REQ-019 o_busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, ACCUM, SCALE, OUT.
REQ-021 IDLE -> ACCUM on i_start; i_mode, i_win_len, i_scale and i_shift SHALL be latched and the element counter cleared on that edge.
REQ-022 o_ready SHALL be 1 only in ACCUM; an element is accepted on any edge where i_valid && o_ready.
REQ-023 Lane accumulators SHALL be ACC_WIDTH = DATA_WIDTH+INDEX_WIDTH+1 bits signed, so the sum cannot overflow.
REQ-024 On the first accepted element, each accumulator SHALL load the element (sign-extended); on later elements it SHALL add the element (average mode) or keep the signed maximum (max mode).
REQ-025 ACCUM -> SCALE SHALL occur on the edge that accepts the element bringing the count to the latched length.
REQ-026 SCALE SHALL last one cycle and register the lane results into o_result; o_valid SHALL rise on the next edge (state OUT).
REQ-027 In average mode, each lane SHALL compute p = acc x scale (signed, full width).
REQ-028 Rounding: if shift > 0, add 2^(shift-1) to p before the arithmetic right shift by shift.
REQ-029 The shifted result SHALL saturate to the signed 2*DATA_WIDTH range [-2^(2*DATA_WIDTH-1), 2^(2*DATA_WIDTH-1)-1].
REQ-030 In max mode, the lane result SHALL be the maximum sign-extended to 2*DATA_WIDTH; scale and shift are ignored.
REQ-031 Latency from the edge accepting the last element to o_valid=1 SHALL be 2 cycles.
REQ-032 In OUT, o_valid and o_result SHALL be held stable until i_ready=1.
REQ-033 On the edge where o_valid && i_ready, the FSM SHALL go OUT -> IDLE and o_valid SHALL fall; a new i_start is accepted from the next cycle.
REQ-034 i_start SHALL be ignored outside IDLE; configuration inputs SHALL be ignored outside the i_start edge.
REQ-035 i_valid while o_ready=0 SHALL be ignored, with no data consumed.

Reset
REQ-036 While i_rst_n=0: state = IDLE; o_valid, o_busy, o_ready, counter, accumulators and o_result all 0.
REQ-037 Reset asserted mid-window SHALL discard the partial window; no o_valid follows reset.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the mode encoding (MODE_AVG=0, MODE_MAX=1) and the ACC_WIDTH derivation.
REQ-039 Per-lane accumulate/scale/round/saturate logic SHALL be one sub-module, pool_lane, instantiated DATA_COPIES times in a generate loop; the top level holds the FSM, counter and configuration registers.

Verification
REQ-040 Average, win=4, lane0 = 10,20,30,40, scale=64, shift=8 -> lane0 o_result = 25, o_valid exactly 2 cycles after the 4th accept.
REQ-041 Max, win=3, lane3 = -5,3,-1 -> lane3 = 3; win=1, lane0 = -128 -> -128 (0xFF80).
REQ-042 Saturation: average, win=32, all lanes 127, scale=127, shift=0 -> every lane 32767; all lanes -128, scale=127 -> every lane -32768.
REQ-043 Rounding: win=1, lane -3, scale=1, shift=1 -> -1; win=0 behaves identically to win=1.
REQ-044 Backpressure: i_ready=0 for 3 cycles in OUT -> o_valid held, o_result unchanged, o_ready=0, i_start ignored; i_ready=1 -> IDLE next cycle.
REQ-045 Reset after 2 of 4 elements, then a fresh window 1,1,1,1 with scale=64, shift=6 -> result 4 with no stale contribution; o_valid=0 throughout reset.
